// File: rtl/seq_detect_param_if.sv
// Serial-input bundle for seq_detect_param: data, control, pattern load and status outputs.
// The master drives the bit stream and controls; the slave (detector) returns y, match_cnt and fill.
interface seq_detect_param_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  localparam int FW = $clog2(N + 1);

  logic          x;
  logic          in_valid;
  logic          clear;
  logic [N-1:0]  pat_in;
  logic          pat_load;
  logic          y;
  logic [CW-1:0] match_cnt;
  logic [FW-1:0] fill;

  modport master (
    output x, in_valid, clear, pat_in, pat_load,
    input  y, match_cnt, fill
  );

  modport slave (
    input  x, in_valid, clear, pat_in, pat_load,
    output y, match_cnt, fill
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a loadable pattern, fill tracking,
// overlapping/non-overlapping match modes and a saturating match counter.
module seq_detect_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int           OVERLAP = 1,
  parameter int           CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_detect_param_if.slave bus
);
  localparam int            FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic [N-1:0]  pat_r, pat_s;
  logic [N-1:0]  hist_r, hist_s;
  logic [FW-1:0] fill_r, fill_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          y_r, y_s;
  logic [N-1:0]  hist_shift_s;
  logic [FW-1:0] fill_inc_s;
  logic          match_s;

  // Next-state: clear beats pat_load beats an accepted bit; y only pulses on a matching accept
  always_comb begin
    pat_s        = pat_r;
    hist_s       = hist_r;
    fill_s       = fill_r;
    cnt_s        = cnt_r;
    y_s          = 1'b0;
    hist_shift_s = {hist_r[N-2:0], bus.x};
    if (fill_r == FILL_FULL) begin
      fill_inc_s = FILL_FULL;
    end else begin
      fill_inc_s = fill_r + FW'(1);
    end
    // Requiring a full history keeps an all-zero pattern from matching the reset-zero register
    match_s = (fill_inc_s == FILL_FULL) && (hist_shift_s == pat_r);

    if (bus.clear) begin
      hist_s = {N{1'b0}};
      fill_s = {FW{1'b0}};
      cnt_s  = {CW{1'b0}};
    end else if (bus.pat_load) begin
      pat_s  = bus.pat_in;
      hist_s = {N{1'b0}};
      fill_s = {FW{1'b0}};
    end else if (bus.in_valid) begin
      hist_s = hist_shift_s;
      fill_s = fill_inc_s;
      if (match_s) begin
        y_s = 1'b1;
        if (cnt_r == CNT_MAX) begin
          cnt_s = cnt_r;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
        if (OVERLAP == 0) begin
          fill_s = {FW{1'b0}};
        end else begin
          fill_s = fill_inc_s;
        end
      end else begin
        y_s = 1'b0;
      end
    end else begin
      y_s = 1'b0;
    end
  end

  // State registers; reset restores the build-time pattern and discards all progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r  <= PATTERN;
      hist_r <= {N{1'b0}};
      fill_r <= {FW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      y_r    <= 1'b0;
    end else begin
      pat_r  <= pat_s;
      hist_r <= hist_s;
      fill_r <= fill_s;
      cnt_r  <= cnt_s;
      y_r    <= y_s;
    end
  end

  assign bus.y         = y_r;
  assign bus.match_cnt = cnt_r;
  assign bus.fill      = fill_r;
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter N, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: reset-time pattern; bit N-1 is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-004 Parameter CW, default 8: width of the match counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 x  input  1  serial data bit.
REQ-008 in_valid  input  1  x is sampled only when in_valid=1.
REQ-009 clear  input  1  synchronous clear of history, fill and counter.
REQ-010 pat_in  input  N  new pattern value.
REQ-011 pat_load  input  1  synchronous load of pat_in into the pattern register.
REQ-012 y  output  1  registered one-cycle match pulse.
REQ-013 match_cnt  output  CW  saturating count of matches.
REQ-014 fill  output  clog2(N+1)  number of valid history bits, 0..N.

Function
REQ-015 The block SHALL hold a pattern register pat[N-1:0], a history shift register hist[N-1:0] and a fill counter.
REQ-016 When in_valid=1, the block SHALL update hist as {hist[N-2:0], x} and increment fill, saturating at N.
REQ-017 A match SHALL be declared on an accepting edge when the post-shift fill equals N and the post-shift hist equals pat.
REQ-018 y SHALL be 1 for exactly the one cycle following each accepting edge that declares a match, and 0 otherwise.
REQ-019 Latency SHALL be one clock: the edge that samples the final pattern bit drives y high.
REQ-020 With OVERLAP=1, the history and fill SHALL be retained after a match, so suffix bits count toward the next match.
REQ-021 With OVERLAP=0, a match SHALL set fill to 0; the next match needs N fresh accepted bits.
REQ-022 match_cnt SHALL increment by 1 on each match and SHALL hold at all-ones (no wrap).
REQ-023 When in_valid=0, hist, fill and match_cnt SHALL hold and y SHALL be 0.
REQ-024 When clear=1, the block SHALL set hist=0, fill=0, match_cnt=0 and y=0, keep pat, and discard x.
REQ-025 When pat_load=1 and clear=0, the block SHALL set pat=pat_in, hist=0, fill=0 and y=0, keep match_cnt, and discard x.
REQ-026 Priority SHALL be rst > clear > pat_load > in_valid.
REQ-027 The all-zeros pattern SHALL NOT match while fill<N, so reset-zero history produces no false match.

Reset
REQ-028 When rst=0, the block SHALL immediately force pat=PATTERN, hist=0, fill=0, match_cnt=0 and y=0, regardless of clk.
REQ-029 When rst=0 arrives mid-sequence, partial progress SHALL be lost; detection restarts from fill=0 after rst returns to 1.
REQ-030 On the first rising edge after rst deasserts, the block SHALL operate normally.

Verification
REQ-031 N=4, PATTERN=1011, OVERLAP=1; feed 1,0,1,1,0,1,1 with in_valid=1 -> y pulses after bits 4 and 7; match_cnt=2.
REQ-032 Same stream with OVERLAP=0 -> y pulses only after bit 4; match_cnt=1; fill=3 at the end.
REQ-033 Feed 1,0 then hold in_valid=0 for 5 cycles, then feed 1,1 -> y=0 during the gap; single pulse after the final 1; match_cnt=1.
REQ-034 With CW=2, drive 5 overlapping matches (stream 1011011011011011) -> match_cnt reads 1, 2, 3, 3, 3; y pulses 5 times.
REQ-035 Partway through (fill=3): (a) assert pat_load with pat_in=0110, then feed 0,1,1,0 -> pat=0110, fill=0, one pulse, counter retained; (b) alternatively assert clear -> match_cnt=0, pat unchanged.
REQ-036 Assert rst=0 between clock edges with fill=3 -> y=0, fill=0 and match_cnt=0 without waiting for a clock edge; the 4th bit after release alone does not match.
